// File: rtl/sbus_to_axi_pkg.sv
// Shared types and constants for the sbus-to-AXI single-beat bridge.
// Optional SBUS_AXI_ERR_EN (in the top) adds the sbus_err response flag.
package sbus_to_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } axi_bridge_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_B     = 3'd0;
    localparam logic [2:0] AXI_SIZE_H     = 3'd1;
    localparam logic [2:0] AXI_SIZE_W     = 3'd2;

    // Halfword only for aligned lane pairs; odd strobe patterns fall back to a full word.
    function automatic logic [2:0] axi_size_from_strb(input logic [3:0] strb);
        logic [2:0] size;
        case (strb)
            4'b1111:                            size = AXI_SIZE_W;
            4'b0011, 4'b1100:                   size = AXI_SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = AXI_SIZE_B;
            default:                            size = AXI_SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sbus_to_axi.sv
// Turns each sbus request into one single-beat AXI read or write, stalling the core until the response.
// Define SBUS_AXI_ERR_EN to add sbus_err, flagging a non-OKAY rresp/bresp in the DONE cycle.
module sbus_to_axi
    import sbus_to_axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic              clk,
    input  logic              resetn,
    // sbus side: request held stable by the master while sbus_stall is high
    input  logic              sbus_en,
    input  logic [3:0]        sbus_we,
    input  logic [31:0]       sbus_addr,
    input  logic [31:0]       sbus_wdata,
    output logic [31:0]       sbus_rdata,
    output logic              sbus_stall,
    // AXI read address / data
    output logic [ID_W-1:0]   arid,
    output logic [31:0]       araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address / data / response
    output logic [ID_W-1:0]   awid,
    output logic [31:0]       awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
`ifdef SBUS_AXI_ERR_EN
    output logic              sbus_err,
`endif
    output axi_bridge_state_t dbg_state_o
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both
    // high; valid is never withdrawn before that edge and its payload stays constant.

    axi_bridge_state_t state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
`ifdef SBUS_AXI_ERR_EN
    logic [1:0]        resp_q, resp_d;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{rlast, rresp, bresp};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef SBUS_AXI_ERR_EN
        resp_d    = resp_q;
`endif
        case (state_q)
            IDLE: begin
                if (sbus_en) begin
                    addr_d    = sbus_addr;
                    we_d      = sbus_we;
                    wdata_d   = sbus_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef SBUS_AXI_ERR_EN
                    resp_d    = AXI_RESP_OKAY;
`endif
                    state_d   = (sbus_we == 4'b0000) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d = rdata;
`ifdef SBUS_AXI_ERR_EN
                    resp_d  = rresp;
`endif
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both have landed.
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
`ifdef SBUS_AXI_ERR_EN
                    resp_d  = bresp;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef SBUS_AXI_ERR_EN
            resp_q    <= AXI_RESP_OKAY;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef SBUS_AXI_ERR_EN
            resp_q    <= resp_d;
`endif
        end
    end

    // The DONE cycle is the only one where a pending request sees stall low.
    always_comb begin
        sbus_stall = 1'b1;
        if (state_q == IDLE)      sbus_stall = sbus_en;
        else if (state_q == DONE) sbus_stall = 1'b0;
    end

    assign sbus_rdata  = rdata_q;
    assign dbg_state_o = state_q;

    assign arid    = AXI_ID;
    assign araddr  = {addr_q[31:2], 2'b00};
    assign arlen   = 4'd0;
    assign arsize  = AXI_SIZE_W;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = axi_size_from_strb(we_q);
    assign awburst = AXI_BURST_INCR;
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = we_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign bready  = (state_q == WR_RESP);

`ifdef SBUS_AXI_ERR_EN
    assign sbus_err = (state_q == DONE) && (resp_q != AXI_RESP_OKAY);
`endif

endmodule

// File: tb/tb_sbus_to_axi.sv
// Directed bench for sbus_to_axi: reads, writes with skewed handshakes, back-to-back, reset mid-read.
// Build with +define+SBUS_AXI_ERR_EN to also exercise sbus_err.
module tb_sbus_to_axi;
    import sbus_to_axi_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sbus_en;
    logic [3:0]        sbus_we;
    logic [31:0]       sbus_addr;
    logic [31:0]       sbus_wdata;
    logic [31:0]       sbus_rdata;
    logic              sbus_stall;
    logic [3:0]        arid, awid, wid;
    logic [31:0]       araddr, awaddr, wdata;
    logic [3:0]        arlen, awlen, wstrb;
    logic [2:0]        arsize, awsize;
    logic [1:0]        arburst, awburst;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic [31:0]       rdata;
    logic [1:0]        rresp, bresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef SBUS_AXI_ERR_EN
    logic              sbus_err;
`endif
    axi_bridge_state_t dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sbus_to_axi #(.ID_W(4), .AXI_ID(4'h5)) dut (
        .clk(clk), .resetn(resetn),
        .sbus_en(sbus_en), .sbus_we(sbus_we), .sbus_addr(sbus_addr),
        .sbus_wdata(sbus_wdata), .sbus_rdata(sbus_rdata), .sbus_stall(sbus_stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef SBUS_AXI_ERR_EN
        .sbus_err(sbus_err),
`endif
        .dbg_state_o(dbg_state)
    );

    // Sample 1 time unit after the rising edge, well away from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; sbus_en = 1'b0; sbus_we = 4'h0; sbus_addr = '0; sbus_wdata = '0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_stall", 32'(sbus_stall), 32'd0);
        chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("rst_rdata", sbus_rdata, 32'h0);
        resetn = 1'b1;

        // Zero-wait read of 0x1FC0_0004
        sbus_en = 1'b1; sbus_we = 4'h0; sbus_addr = 32'h1FC0_0004;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_stall_idle", 32'(sbus_stall), 32'd1);
        tick();
        chk("rd_state_ar", 32'(dbg_state), 32'(RD_ADDR));
        chk("rd_arvalid", 32'(arvalid), 32'd1);
        chk("rd_araddr", araddr, 32'h1FC0_0004);
        chk("rd_ar_fixed", 32'({arid, arlen, arsize, arburst}), 32'({4'h5, 4'h0, 3'd2, 2'b01}));
        chk("rd_stall_ar", 32'(sbus_stall), 32'd1);
        tick();
        chk("rd_state_r", 32'(dbg_state), 32'(RD_DATA));
        chk("rd_rready", 32'(rready), 32'd1);
        chk("rd_arvalid_drop", 32'(arvalid), 32'd0);
        chk("rd_stall_r", 32'(sbus_stall), 32'd1);
        tick();
        chk("rd_state_done", 32'(dbg_state), 32'(DONE));
        chk("rd_stall_done", 32'(sbus_stall), 32'd0);
        chk("rd_rdata", sbus_rdata, 32'hDEAD_BEEF);
`ifdef SBUS_AXI_ERR_EN
        chk("rd_err_okay", 32'(sbus_err), 32'd0);
`endif
        sbus_en = 1'b0; arready = 1'b0; rvalid = 1'b0;
        tick();
        chk("rd_back_idle", 32'(dbg_state), 32'(IDLE));
        chk("rd_rdata_hold", sbus_rdata, 32'hDEAD_BEEF);

        // Single-byte write, AW and W accepted together
        sbus_en = 1'b1; sbus_we = 4'b0100; sbus_addr = 32'h8000_0002; sbus_wdata = 32'h00AB_0000;
        awready = 1'b1; wready = 1'b1;
        tick();
        chk("wr_state_req", 32'(dbg_state), 32'(WR_REQ));
        chk("wr_valids", 32'({awvalid, wvalid}), 32'b11);
        chk("wr_awaddr", awaddr, 32'h8000_0002);
        chk("wr_awsize", 32'(awsize), 32'd0);
        chk("wr_wstrb", 32'(wstrb), 32'b0100);
        chk("wr_wdata", wdata, 32'h00AB_0000);
        chk("wr_aw_fixed", 32'({awid, wid, awlen, awburst, wlast}), 32'({4'h5, 4'h5, 4'h0, 2'b01, 1'b1}));
        tick();
        chk("wr_state_resp", 32'(dbg_state), 32'(WR_RESP));
        chk("wr_valids_drop", 32'({awvalid, wvalid}), 32'b00);
        chk("wr_bready", 32'(bready), 32'd1);
        awready = 1'b0; wready = 1'b0;
        tick();
        chk("wr_wait_b", 32'({32'(dbg_state), 31'd0, sbus_stall} != 0), 32'd1);
        chk("wr_wait_state", 32'(dbg_state), 32'(WR_RESP));
        bvalid = 1'b1;
        tick();
        chk("wr_done_after_b", 32'(dbg_state), 32'(DONE));
        chk("wr_stall_done", 32'(sbus_stall), 32'd0);
        bvalid = 1'b0; sbus_en = 1'b0;
        tick();

        // W accepted well before AW
        sbus_en = 1'b1; sbus_we = 4'b1111; sbus_addr = 32'h0000_0100; sbus_wdata = 32'h1234_5678;
        tick();
        chk("wfirst_awsize", 32'(awsize), 32'd2);
        wready = 1'b1;
        tick();
        chk("wfirst_w_only", 32'({awvalid, wvalid}), 32'b10);
        wready = 1'b0;
        tick(); tick();
        chk("wfirst_aw_held", 32'({awvalid, wvalid}), 32'b10);
        chk("wfirst_state", 32'(dbg_state), 32'(WR_REQ));
        awready = 1'b1;
        tick();
        chk("wfirst_resp", 32'(dbg_state), 32'(WR_RESP));
        chk("wfirst_aw_drop", 32'(awvalid), 32'd0);
        awready = 1'b0; bvalid = 1'b1;
        tick();
        chk("wfirst_done", 32'(dbg_state), 32'(DONE));
        chk("wfirst_no_2nd_b", 32'(bready), 32'd0);
        bvalid = 1'b0; sbus_en = 1'b0;
        tick();
        chk("wfirst_idle", 32'({32'(dbg_state), bready, awvalid}), 32'({32'(IDLE), 2'b00}));

        // AW accepted before W
        sbus_en = 1'b1; sbus_we = 4'b0011; sbus_addr = 32'h0000_0200; sbus_wdata = 32'h0000_BEEF;
        tick();
        chk("awfirst_awsize", 32'(awsize), 32'd1);
        awready = 1'b1;
        tick();
        chk("awfirst_aw_only", 32'({awvalid, wvalid}), 32'b01);
        awready = 1'b0;
        tick();
        chk("awfirst_w_held", 32'({awvalid, wvalid}), 32'b01);
        wready = 1'b1;
        tick();
        chk("awfirst_resp", 32'(dbg_state), 32'(WR_RESP));
        wready = 1'b0; bvalid = 1'b1;
        tick();
        chk("awfirst_done", 32'(dbg_state), 32'(DONE));
        bvalid = 1'b0; sbus_en = 1'b0;
        tick();

        // Irregular strobe falls back to word size
        sbus_en = 1'b1; sbus_we = 4'b0110; sbus_addr = 32'h0000_0300;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        tick();
        chk("odd_awsize", 32'(awsize), 32'd2);
        tick(); tick();
        chk("odd_done", 32'(dbg_state), 32'(DONE));
        sbus_en = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();

        // Back-to-back read then write with sbus_en held high
        sbus_en = 1'b1; sbus_we = 4'h0; sbus_addr = 32'h0000_0023;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        chk("b2b_araddr", araddr, 32'h0000_0020);
        tick(); tick();
        chk("b2b_rd_done", 32'(dbg_state), 32'(DONE));
        chk("b2b_rdata", sbus_rdata, 32'hCAFE_F00D);
        sbus_we = 4'b1000; sbus_addr = 32'h0000_0044; sbus_wdata = 32'h1100_0000;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        tick();
        chk("b2b_idle", 32'(dbg_state), 32'(IDLE));
        chk("b2b_idle_stall", 32'(sbus_stall), 32'd1);
        chk("b2b_no_dup", 32'({arvalid, awvalid, wvalid}), 32'd0);
        tick();
        chk("b2b_wr_state", 32'(dbg_state), 32'(WR_REQ));
        chk("b2b_awaddr", awaddr, 32'h0000_0044);
        chk("b2b_awsize", 32'(awsize), 32'd0);
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        tick();
        chk("b2b_wr_done", 32'(dbg_state), 32'(DONE));
        chk("b2b_rdata_kept", sbus_rdata, 32'hCAFE_F00D);
        bvalid = 1'b0; sbus_en = 1'b0;
        tick();

        // Reset while waiting in RD_DATA
        sbus_en = 1'b1; sbus_we = 4'h0; sbus_addr = 32'h0000_0008; arready = 1'b1;
        tick(); tick();
        chk("rst_mid_rready", 32'(rready), 32'd1);
        resetn = 1'b0;
        tick();
        chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_mid_valids", 32'({arvalid, rready}), 32'd0);
        chk("rst_mid_stall_en", 32'(sbus_stall), 32'd1);
        chk("rst_mid_rdata", sbus_rdata, 32'h0);
        sbus_en = 1'b0;
        #1;
        chk("rst_mid_stall_noen", 32'(sbus_stall), 32'd0);
        resetn = 1'b1; arready = 1'b0;
        tick();

`ifdef SBUS_AXI_ERR_EN
        // Read returning SLVERR
        sbus_en = 1'b1; sbus_we = 4'h0; sbus_addr = 32'h0000_0010;
        arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0BAD_0BAD;
        tick(); tick(); tick();
        chk("err_done", 32'(dbg_state), 32'(DONE));
        chk("err_high", 32'(sbus_err), 32'd1);
        sbus_en = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        tick();
        chk("err_low_after", 32'(sbus_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
